// File: rtl/pwm_softstart_ctrl.sv
// pwm_softstart_ctrl: fixed-frequency PWM generator with soft-start/soft-stop.
// Owns the period counter (0..TOP). The applied duty ramps toward the goal in
// steps of at most STEP counts, changing only at period boundaries.
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           1 = run / ramp up, 0 = ramp down to zero and stop
//   duty_target  requested high time in counts, clamped to TOP+1
//   pwm          registered PWM output
//   duty_cur     duty currently applied
//   ramping      1 while ramping up/retargeting or ramping down
//   at_target    1 while holding the clamped target
//   period_tick  1 in the cycle where the counter wraps TOP->0
module pwm_softstart_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TOP      = 5000,
  parameter int unsigned STEP     = 50,
  parameter int unsigned RAMP_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] duty_target,
  output logic             pwm,
  output logic [CNT_W-1:0] duty_cur,
  output logic             ramping,
  output logic             at_target,
  output logic             period_tick
);

  localparam int unsigned W1    = CNT_W + 1;
  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [CNT_W-1:0] TOP_C    = CNT_W'(TOP);
  localparam logic [W1-1:0]    FULL_X   = W1'(TOP + 1);
  localparam logic [W1-1:0]    STEP_X   = W1'(STEP);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RAMP,
    ST_HOLD,
    ST_STOP
  } state_t;

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_duty, w_duty_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic             r_pwm, r_ramping, r_at_target, r_period_tick;

  logic             w_tick, w_step, w_up;
  logic [W1-1:0]    w_duty_x, w_tgt_x, w_tgt_clamp, w_goal;
  logic [W1-1:0]    w_gap, w_delta, w_duty_step;

  // Goal and bounded step, computed one bit wider so TOP+1 and duty+STEP never wrap
  assign w_duty_x    = {1'b0, r_duty};
  assign w_tgt_x     = {1'b0, duty_target};
  assign w_tgt_clamp = (w_tgt_x > FULL_X) ? FULL_X : w_tgt_x;
  assign w_goal      = (r_state == ST_STOP) ? '0 : w_tgt_clamp;
  assign w_up        = (w_goal >= w_duty_x);
  assign w_gap       = w_up ? (w_goal - w_duty_x) : (w_duty_x - w_goal);
  assign w_delta     = (w_gap > STEP_X) ? STEP_X : w_gap;
  assign w_duty_step = w_up ? (w_duty_x + w_delta) : (w_duty_x - w_delta);

  // Wrap cycle of a running counter; a step happens on every RAMP_DIV-th wrap
  assign w_tick = (r_state != ST_OFF) && (r_cnt == TOP_C);
  assign w_step = w_tick && (r_div == DIV_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; en is honoured every cycle, duty only moves on w_step
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OFF: begin
        if (en) w_state_nxt = ST_RAMP;
      end
      ST_RAMP: begin
        if (!en) w_state_nxt = ST_STOP;
        else if (w_step && (w_duty_step == w_goal)) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!en) w_state_nxt = ST_STOP;
        else if (w_tgt_clamp != w_duty_x) w_state_nxt = ST_RAMP;
      end
      ST_STOP: begin
        if (en) w_state_nxt = ST_RAMP;
        else if (w_tick && (r_duty == '0)) w_state_nxt = ST_OFF;
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  // Counter, duty and divider next values
  always_comb begin
    w_cnt_nxt  = r_cnt + CNT_W'(1);
    w_duty_nxt = r_duty;
    w_div_nxt  = r_div;
    if ((r_state == ST_OFF) || w_tick) w_cnt_nxt = '0;
    if (r_state == ST_OFF) begin
      w_div_nxt = '0;
    end else if (w_step) begin
      w_duty_nxt = CNT_W'(w_duty_step);
      w_div_nxt  = '0;
    end else if (w_tick) begin
      w_div_nxt = r_div + DIV_W'(1);
    end
  end

  // Datapath and output registers; period_tick is looked ahead so it lines up with cnt==TOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_duty        <= '0;
      r_div         <= '0;
      r_pwm         <= 1'b0;
      r_ramping     <= 1'b0;
      r_at_target   <= 1'b0;
      r_period_tick <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_duty        <= w_duty_nxt;
      r_div         <= w_div_nxt;
      r_pwm         <= (r_state != ST_OFF) && (r_cnt < r_duty);
      r_ramping     <= (w_state_nxt == ST_RAMP) || (w_state_nxt == ST_STOP);
      r_at_target   <= (w_state_nxt == ST_HOLD);
      r_period_tick <= (w_state_nxt != ST_OFF) && (w_cnt_nxt == TOP_C);
    end
  end

  assign pwm         = r_pwm;
  assign duty_cur    = r_duty;
  assign ramping     = r_ramping;
  assign at_target   = r_at_target;
  assign period_tick = r_period_tick;

endmodule

// File: tb/tb_pwm_softstart_ctrl.sv
// Testbench for pwm_softstart_ctrl: two instances (RAMP_DIV=1 and RAMP_DIV=3)
// driven by the same directed then random stimulus, compared every cycle
// against a behavioural model, plus literal expectations for known sequences.
module tb_pwm_softstart_ctrl;

  localparam int TOP  = 99;
  localparam int STEP = 10;

  localparam int M_OFF  = 0;
  localparam int M_RAMP = 1;
  localparam int M_HOLD = 2;
  localparam int M_STOP = 3;

  typedef struct {
    int mode;
    int cnt;
    int duty;
    int dv;
    bit pwm;
  } mdl_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] duty_target;

  logic        a_pwm, a_ramping, a_at_target, a_tick;
  logic [15:0] a_duty;
  logic        b_pwm, b_ramping, b_at_target, b_tick;
  logic [15:0] b_duty;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 0;

  mdl_t ma, mb;

  pwm_softstart_ctrl #(.CNT_W(16), .TOP(TOP), .STEP(STEP), .RAMP_DIV(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .duty_target(duty_target),
    .pwm(a_pwm), .duty_cur(a_duty), .ramping(a_ramping),
    .at_target(a_at_target), .period_tick(a_tick)
  );

  pwm_softstart_ctrl #(.CNT_W(16), .TOP(TOP), .STEP(STEP), .RAMP_DIV(3)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .duty_target(duty_target),
    .pwm(b_pwm), .duty_cur(b_duty), .ramping(b_ramping),
    .at_target(b_at_target), .period_tick(b_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = M_OFF;
    r.cnt  = 0;
    r.duty = 0;
    r.dv   = 0;
    r.pwm  = 1'b0;
    return r;
  endfunction

  // One clock of the spec's behaviour: phase in the period, bounded duty moves, mode rules
  function automatic mdl_t mdl_next(input mdl_t m, input bit e, input int tgt, input int rdiv);
    mdl_t n;
    int   want, goal, move;
    bit   wrap, stepnow;
    n       = m;
    want    = (tgt > TOP + 1) ? TOP + 1 : tgt;
    goal    = (m.mode == M_STOP) ? 0 : want;
    wrap    = (m.mode != M_OFF) && (m.cnt == TOP);
    stepnow = wrap && (m.dv == rdiv - 1);
    n.pwm   = (m.mode != M_OFF) && (m.cnt < m.duty);
    n.cnt   = (m.mode == M_OFF || wrap) ? 0 : m.cnt + 1;
    if (m.mode == M_OFF) begin
      n.dv = 0;
    end else if (stepnow) begin
      move = goal - m.duty;
      if (move > STEP) move = STEP;
      if (move < -STEP) move = -STEP;
      n.duty = m.duty + move;
      n.dv   = 0;
    end else if (wrap) begin
      n.dv = m.dv + 1;
    end
    case (m.mode)
      M_OFF:  if (e) n.mode = M_RAMP;
      M_RAMP: if (!e) n.mode = M_STOP;
              else if (stepnow && n.duty == goal) n.mode = M_HOLD;
      M_HOLD: if (!e) n.mode = M_STOP;
              else if (want != m.duty) n.mode = M_RAMP;
      M_STOP: if (e) n.mode = M_RAMP;
              else if (wrap && m.duty == 0) n.mode = M_OFF;
      default: n.mode = M_OFF;
    endcase
    return n;
  endfunction

  // Reference models follow the same async reset as the DUTs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= mdl_reset();
      mb <= mdl_reset();
    end else begin
      ma <= mdl_next(ma, en, int'(duty_target), 1);
      mb <= mdl_next(mb, en, int'(duty_target), 3);
    end
  end

  // Per-cycle comparison, sampled away from the clock edge
  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      check("A.pwm",       int'(a_pwm),       int'(ma.pwm));
      check("A.duty_cur",  int'(a_duty),      ma.duty);
      check("A.ramping",   int'(a_ramping),   int'(ma.mode == M_RAMP || ma.mode == M_STOP));
      check("A.at_target", int'(a_at_target), int'(ma.mode == M_HOLD));
      check("A.tick",      int'(a_tick),      int'(ma.mode != M_OFF && ma.cnt == TOP));
      check("B.pwm",       int'(b_pwm),       int'(mb.pwm));
      check("B.duty_cur",  int'(b_duty),      mb.duty);
      check("B.ramping",   int'(b_ramping),   int'(mb.mode == M_RAMP || mb.mode == M_STOP));
      check("B.at_target", int'(b_at_target), int'(mb.mode == M_HOLD));
      check("B.tick",      int'(b_tick),      int'(mb.mode != M_OFF && mb.cnt == TOP));
    end
  end

  // Wait for the next wrap of instance A, then one more cycle so the new duty is visible
  task automatic tick_a(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (a_tick) seen = 1'b1;
    end
    check({nm, ".tick_seen"}, int'(seen), 1);
    @(negedge clk);
  endtask

  task automatic tick_b(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (b_tick) seen = 1'b1;
    end
    check({nm, ".tick_seen"}, int'(seen), 1);
    @(negedge clk);
  endtask

  task automatic count_pwm_a(output int c);
    c = 0;
    repeat (TOP + 1) begin
      @(negedge clk);
      c += int'(a_pwm);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp1[4];
    int exp4[6];
    int c;
    int quiet;
    exp1 = '{10, 20, 30, 35};
    exp4 = '{0, 0, 10, 10, 10, 20};

    rst_n       = 1'b0;
    en          = 1'b0;
    duty_target = 16'd35;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("reset.pwm",  int'(a_pwm), 0);
    check("reset.duty", int'(a_duty), 0);
    check("reset.ramp", int'(a_ramping), 0);
    check("reset.tick", int'(a_tick), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Soft start to 35
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick_a("s1");
      check("s1.duty", int'(a_duty), exp1[k]);
    end
    check("s1.at_target", int'(a_at_target), 1);
    count_pwm_a(c);
    check("s1.pwm_high", c, 35);

    // Clamped target above TOP+1
    duty_target = 16'd500;
    for (int k = 0; k < 7; k++) begin
      tick_a("s2");
      check("s2.duty", int'(a_duty), (k < 6) ? 45 + 10 * k : 100);
    end
    check("s2.at_target", int'(a_at_target), 1);
    count_pwm_a(c);
    check("s2.pwm_high", c, 100);

    // Soft stop down to OFF
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick_a("s3");
      check("s3.duty", int'(a_duty), 90 - 10 * k);
    end
    check("s3.ramping", int'(a_ramping), 1);
    tick_a("s3.off");
    check("s3.off_ramping", int'(a_ramping), 0);
    check("s3.off_at_target", int'(a_at_target), 0);
    quiet = 0;
    repeat (150) begin
      @(negedge clk);
      quiet += int'(a_tick) + int'(a_pwm);
    end
    check("s3.off_quiet", quiet, 0);

    // Divided ramp on instance B
    do_reset();
    duty_target = 16'd20;
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick_b("s4");
      check("s4.duty", int'(b_duty), exp4[k]);
    end

    // Mid-period retarget downward
    do_reset();
    duty_target = 16'd35;
    for (int k = 0; k < 4; k++) tick_a("s5.up");
    check("s5.hold", int'(a_duty), 35);
    repeat (50) @(negedge clk);
    duty_target = 16'd15;
    @(negedge clk);
    check("s5.ramping", int'(a_ramping), 1);
    check("s5.unchanged", int'(a_duty), 35);
    tick_a("s5");
    check("s5.duty1", int'(a_duty), 25);
    tick_a("s5");
    check("s5.duty2", int'(a_duty), 15);
    check("s5.at_target", int'(a_at_target), 1);

    // Async reset mid-period while pwm is high
    duty_target = 16'd35;
    tick_a("s6");
    check("s6.duty", int'(a_duty), 25);
    repeat (15) @(negedge clk);
    check("s6.pwm_before", int'(a_pwm), 1);
    #1 rst_n = 1'b0;
    #1;
    check("s6.pwm_async", int'(a_pwm), 0);
    check("s6.duty_async", int'(a_duty), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick_a("s6.restart");
    check("s6.restart_duty", int'(a_duty), 10);

    // Random phase, checked by the model every cycle
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 399) == 0) en = ~en;
      if ($urandom_range(0, 149) == 0) begin
        if ($urandom_range(0, 9) == 0) duty_target = 16'hFFFF;
        else duty_target = 16'($urandom_range(0, 130));
      end
      if ($urandom_range(0, 5999) == 0) begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_softstart_ctrl.md
Name: pwm_softstart_ctrl

Overview:
Soft-start/soft-stop sequencer and generator for the board's fixed-frequency PWM output. Owns the period counter. Ramps the applied duty toward a requested target in bounded steps, updating only at period boundaries so no pulse is ever truncated or glitched. On disable, ramps duty down to zero before stopping the counter. Sits between the control logic that chooses duty_target and the power-stage pin.

Parameters:
CNT_W, 16, width of the period counter, duty values and compare values.
TOP, 5000, counter top value; the period is TOP+1 clk cycles.
STEP, 50, maximum change of the applied duty per ramp step, in counts.
RAMP_DIV, 1, number of whole periods between ramp steps (>=1).

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  level request: 1 = run/ramp up, 0 = ramp down and stop.
duty_target  in  CNT_W  requested high-time in counts; values above TOP+1 are clamped to TOP+1 (100%).
pwm  out  1  registered PWM output.
duty_cur  out  CNT_W  duty currently applied (registered).
ramping  out  1  1 while in state RAMP or STOP.
at_target  out  1  1 in HOLD (duty_cur equals the clamped target).
period_tick  out  1  one-cycle pulse in the cycle where the counter wraps TOP->0.

Behaviour:
- Reset (async assert, sync release): state=OFF, cnt=0, duty_cur=0, pwm=0, ramping=0, at_target=0, period_tick=0, divider=0.
- Counter: cnt free-runs 0..TOP in all states except OFF. In OFF, cnt is held at 0.
- period_tick=1 exactly in the cycle where cnt==TOP and cnt is not held.
- pwm <= (state!=OFF) && (cnt < duty_cur). Registered; 1-cycle latency from cnt.
- duty_cur=0 gives constant 0. duty_cur=TOP+1 gives constant 1.
- duty_cur changes only on the period_tick cycle. The new value applies from the following cnt=0.
- Step rule: on a period_tick where the divider has reached RAMP_DIV-1, duty_cur moves toward the goal by min(STEP, |goal-duty_cur|), with no overshoot. The divider then resets to 0; otherwise the divider increments.
- Goal: the clamped duty_target in RAMP and HOLD; 0 in STOP.
- Width rules: all arithmetic is in CNT_W+1 bits, so TOP+1 and duty+STEP never wrap.
- States and transitions:
  - OFF: en=1 -> RAMP. cnt starts at 0 the next cycle; divider=0.
  - RAMP: duty_cur==goal at a step -> HOLD. en=0 -> STOP, evaluated every cycle.
  - HOLD: clamped target != duty_cur -> RAMP. en=0 -> STOP.
  - STOP: en=1 -> RAMP; the ramp resumes from the present duty_cur with no reset to 0. duty_cur==0 on a period_tick -> OFF.
- A target change mid-ramp retargets at the next step. Ramping is bidirectional, so a target below duty_cur ramps down.
- Simultaneous en=0 and a target change: STOP wins.
- en toggling within one period: the state follows en; duty still changes only at boundaries.
- Reset asserted mid-period forces the reset values immediately, including pwm=0 asynchronously.

Test Plan:
- TOP=99, STEP=10, RAMP_DIV=1, target=35, en 0->1 -> duty_cur sequence 10, 20, 30, 35 at consecutive period_ticks. at_target=1 after the 4th tick. pwm high for 10/20/30/35 cycles of each 100-cycle period.
- In HOLD at 35, set target=500 (above TOP) -> duty ramps 45…95, 100. pwm is constant 1 at 100. Target clamp verified.
- In HOLD at 100, drop en -> duty 90…0 over 10 periods, then OFF: cnt held at 0, pwm=0, ramping=0.
- RAMP_DIV=3, target=20 -> duty changes only every 3rd period_tick: 10 at tick 3, 20 at tick 6.
- Mid-period target change (35->15 at cnt=50) -> duty_cur unchanged until the next tick, then 25, then 15. No pwm pulse shorter than either duty.
- rst_n low at cnt=40 during RAMP -> pwm, duty_cur and cnt are 0 immediately. After release with en=1, ramping restarts from 0.
